unidad_cortocircuito: RTL and testbench
=======================================

UNIDAD_CORTOCIRCUITO -- requirements
Module: unidad_cortocircuito

Interface
REQ-001 SHALL have parameter NREG, default 5: register-address width.
REQ-002 SHALL have parameter CORTOCIRCUITO, default 3: forwarding-select width.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_id_valid  input  1  ID stage holds a real instruction.
REQ-006 SHALL have ports i_id_rs and i_id_rt  input  NREG  source registers of the ID instruction.
REQ-007 SHALL have ports i_id_use_rs and i_id_use_rt  input  1  ID instruction reads rs / rt.
REQ-008 SHALL have port i_id_dest  input  NREG  destination register of the ID instruction.
REQ-009 SHALL have port i_id_reg_write  input  1  ID instruction writes the register file.
REQ-010 SHALL have port i_id_mem_read  input  1  ID instruction is a load.
REQ-011 SHALL have port i_flush  input  1  kill the ID instruction (taken branch/jump).
REQ-012 SHALL have ports o_corto_cir_regA and o_corto_cir_regB  output  CORTOCIRCUITO  forwarding selects for the EX-stage ALU operands.
REQ-013 SHALL have port o_stall  output  1  hold PC and IF/ID; insert bubble into EX.
REQ-014 SHALL have port o_stall_count  output  16  saturating count of stall cycles.

Function
REQ-015 SHALL keep shadow EX, MEM and WB slots, each holding valid, dest, reg_write and mem_read.
REQ-016 Each non-stall, non-flush edge SHALL advance WB<=MEM, MEM<=EX, EX<=ID fields (valid = i_id_valid).
REQ-017 On a stall or flush edge, MEM and WB SHALL still advance; EX SHALL load a bubble (valid=0, reg_write=0).
REQ-018 Select codes SHALL be: 3'b001 = EX/MEM result, 3'b010 = MEM/WB result, 3'b000 = ID/EX register value.
REQ-019 o_corto_cir_regA/B SHALL be registered: computed from the ID instruction and the current EX/MEM slots, loaded on the edge the instruction enters EX.
REQ-020 regA SHALL be 001 when i_id_use_rs, EX slot valid, reg_write, dest==i_id_rs and dest!=0.
REQ-021 Otherwise regA SHALL be 010 when the same match holds against the MEM slot.
REQ-022 Otherwise regA SHALL be 000; EX match has priority over MEM match.
REQ-023 regB SHALL follow REQ-020..022 using i_id_use_rt and i_id_rt.
REQ-024 Register 0 SHALL never produce a non-zero select.
REQ-025 When a bubble enters EX, both selects SHALL load 000.
REQ-026 SHALL implement FSM states RUN and STALL.
REQ-027 In RUN, o_stall SHALL assert combinationally when i_id_valid, the EX slot is a valid load, its dest!=0, and dest matches a used rs or rt.
REQ-028 An asserted o_stall SHALL move the FSM to STALL on the next edge.
REQ-029 STALL SHALL last exactly one cycle with o_stall=0 and return to RUN.
REQ-030 After the stall, the held instruction SHALL receive 010 for the load-matched operand.
REQ-031 A back-to-back load-use hazard SHALL be able to stall again on the cycle after STALL.
REQ-032 i_flush SHALL override o_stall: no stall, no FSM change, bubble enters EX.
REQ-033 o_stall_count SHALL increment on each edge with o_stall=1 and saturate at 16'hFFFF.
REQ-034 A WB-to-ID dependency SHALL produce no forwarding; the register file's first-half write covers it.

Reset
REQ-035 While i_reset=0, all slots SHALL be invalid, selects 000, o_stall 0, count 0 and FSM RUN, independent of i_clk.
REQ-036 Reset asserted mid-stall SHALL abort the stall immediately.
REQ-037 The first edge after reset release SHALL operate normally from RUN.

Verification
REQ-038 add r3,r1,r2 then sub r5,r3,r4 -> sub enters EX with regA=001, regB=000, o_stall never asserted.
REQ-039 add r3, independent nop-like instruction, then or r6,r7,r3 -> or enters EX with regA=000, regB=010.
REQ-040 lw r2,0(r1) then add r4,r2,r5 -> o_stall=1 one cycle, one bubble, add enters EX with regA=010, count=1.
REQ-041 Writes to r0 followed by reads of r0 -> all selects 000; flush asserted during a load-use hazard -> o_stall=0, bubble in EX.
REQ-042 Reset pulsed while in STALL -> outputs 000/0/0 asynchronously, FSM RUN; count held at 16'hFFFF by forced stalls stays saturated.

Source files
------------

// File: rtl/unidad_cortocircuito.sv
// Forwarding and load-use hazard unit for a 5-stage pipeline.
// Tracks shadow EX/MEM/WB slots and produces registered ALU operand selects.
module unidad_cortocircuito #(
  parameter int NREG          = 5,
  parameter int CORTOCIRCUITO = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_id_valid,
  input  logic [NREG-1:0]          i_id_rs,
  input  logic [NREG-1:0]          i_id_rt,
  input  logic                     i_id_use_rs,
  input  logic                     i_id_use_rt,
  input  logic [NREG-1:0]          i_id_dest,
  input  logic                     i_id_reg_write,
  input  logic                     i_id_mem_read,
  input  logic                     i_flush,
  output logic [CORTOCIRCUITO-1:0] o_corto_cir_regA,
  output logic [CORTOCIRCUITO-1:0] o_corto_cir_regB,
  output logic                     o_stall,
  output logic [15:0]              o_stall_count
);

  // state | meaning
  // RUN   | normal issue; load-use hazard in ID raises o_stall
  // STALL | one cycle after a stall; held instruction enters EX, no new stall
  typedef enum logic {RUN, STALL} state_t;

  localparam logic [CORTOCIRCUITO-1:0] SEL_REG   = '0;
  localparam logic [CORTOCIRCUITO-1:0] SEL_EXMEM = CORTOCIRCUITO'(1);
  localparam logic [CORTOCIRCUITO-1:0] SEL_MEMWB = CORTOCIRCUITO'(2);

  state_t state, state_nxt;

  logic            ex_valid, ex_reg_write, ex_mem_read;
  logic [NREG-1:0] ex_dest;
  logic            mem_valid, mem_reg_write, mem_mem_read;
  logic [NREG-1:0] mem_dest;
  logic            wb_valid, wb_reg_write, wb_mem_read;
  logic [NREG-1:0] wb_dest;
  logic            wb_unused;

  logic [CORTOCIRCUITO-1:0] sel_a, sel_b;
  logic [15:0]              stall_count_q;
  logic                     load_hazard, bubble;

  // WB slot is tracked for completeness; its writes reach ID through the register file.
  assign wb_unused = ^{wb_valid, wb_reg_write, wb_mem_read, wb_dest};

  function automatic logic [CORTOCIRCUITO-1:0] fwd_sel(
    input logic            use_src,
    input logic [NREG-1:0] src,
    input logic            exv,
    input logic            exw,
    input logic [NREG-1:0] exd,
    input logic            memv,
    input logic            memw,
    input logic [NREG-1:0] memd
  );
    logic [CORTOCIRCUITO-1:0] sel;
    sel = SEL_REG;
    if (use_src && src != '0) begin
      if (exv && exw && exd == src)
        sel = SEL_EXMEM;
      else if (memv && memw && memd == src)
        sel = SEL_MEMWB;
    end
    return sel;
  endfunction

  always_comb begin
    load_hazard = i_id_valid && ex_valid && ex_mem_read && (ex_dest != '0) &&
                  ((i_id_use_rs && ex_dest == i_id_rs) ||
                   (i_id_use_rt && ex_dest == i_id_rt));
    sel_a = fwd_sel(i_id_use_rs, i_id_rs, ex_valid, ex_reg_write, ex_dest,
                    mem_valid, mem_reg_write, mem_dest);
    sel_b = fwd_sel(i_id_use_rt, i_id_rt, ex_valid, ex_reg_write, ex_dest,
                    mem_valid, mem_reg_write, mem_dest);
  end

  // Flush wins over a stall: the ID instruction is dead, so there is nothing to hold.
  always_comb begin
    state_nxt = state;
    o_stall   = 1'b0;
    case (state)
      RUN: begin
        if (load_hazard && !i_flush) begin
          o_stall   = 1'b1;
          state_nxt = STALL;
        end
      end
      STALL:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign bubble = o_stall || i_flush;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_dest       <= '0;
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_dest      <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_read   <= 1'b0;
      wb_dest       <= '0;
    end else begin
      wb_valid      <= mem_valid;
      wb_reg_write  <= mem_reg_write;
      wb_mem_read   <= mem_mem_read;
      wb_dest       <= mem_dest;
      mem_valid     <= ex_valid;
      mem_reg_write <= ex_reg_write;
      mem_mem_read  <= ex_mem_read;
      mem_dest      <= ex_dest;
      if (bubble) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_dest      <= '0;
      end else begin
        ex_valid     <= i_id_valid;
        ex_reg_write <= i_id_reg_write;
        ex_mem_read  <= i_id_mem_read;
        ex_dest      <= i_id_dest;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_corto_cir_regA <= SEL_REG;
      o_corto_cir_regB <= SEL_REG;
    end else if (bubble) begin
      o_corto_cir_regA <= SEL_REG;
      o_corto_cir_regB <= SEL_REG;
    end else begin
      o_corto_cir_regA <= sel_a;
      o_corto_cir_regB <= sel_b;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      stall_count_q <= '0;
    else if (o_stall && stall_count_q != 16'hFFFF)
      stall_count_q <= stall_count_q + 16'd1;
  end

  assign o_stall_count = stall_count_q;

endmodule

// File: tb/tb_unidad_cortocircuito.sv
// Directed bench for unidad_cortocircuito: vector table for the main pipeline
// scenarios plus hand sequences for back-to-back stalls, reset and saturation.
module tb_unidad_cortocircuito;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_id_valid;
  logic [4:0]  i_id_rs, i_id_rt, i_id_dest;
  logic        i_id_use_rs, i_id_use_rt;
  logic        i_id_reg_write, i_id_mem_read, i_flush;
  logic [2:0]  o_corto_cir_regA, o_corto_cir_regB;
  logic        o_stall;
  logic [15:0] o_stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  unidad_cortocircuito #(.NREG(5), .CORTOCIRCUITO(3)) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_id_valid       (i_id_valid),
    .i_id_rs          (i_id_rs),
    .i_id_rt          (i_id_rt),
    .i_id_use_rs      (i_id_use_rs),
    .i_id_use_rt      (i_id_use_rt),
    .i_id_dest        (i_id_dest),
    .i_id_reg_write   (i_id_reg_write),
    .i_id_mem_read    (i_id_mem_read),
    .i_flush          (i_flush),
    .o_corto_cir_regA (o_corto_cir_regA),
    .o_corto_cir_regB (o_corto_cir_regB),
    .o_stall          (o_stall),
    .o_stall_count    (o_stall_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs, rt;
    logic        urs, urt;
    logic [4:0]  d;
    logic        rw, mr, fl;
    logic        stall;
    logic [2:0]  a, b;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic [4:0] d,
                              input logic rw, input logic mr, input logic fl,
                              input logic stall, input logic [2:0] a, input logic [2:0] b,
                              input logic [15:0] cnt);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.d = d;
    t.rw = rw; t.mr = mr; t.fl = fl; t.stall = stall; t.a = a; t.b = b; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    i_id_valid     = t.v;
    i_id_rs        = t.rs;
    i_id_rt        = t.rt;
    i_id_use_rs    = t.urs;
    i_id_use_rt    = t.urt;
    i_id_dest      = t.d;
    i_id_reg_write = t.rw;
    i_id_mem_read  = t.mr;
    i_flush        = t.fl;
  endtask

  // Drive at negedge, check combinational stall, then check registered outputs after the edge.
  task automatic step(input vec_t t, input string nm);
    @(negedge i_clk);
    drive(t);
    #1 chk({nm, " stall"}, {15'd0, o_stall}, {15'd0, t.stall});
    @(posedge i_clk);
    #1;
    chk({nm, " regA"}, {13'd0, o_corto_cir_regA}, {13'd0, t.a});
    chk({nm, " regB"}, {13'd0, o_corto_cir_regB}, {13'd0, t.b});
    chk({nm, " count"}, o_stall_count, t.cnt);
  endtask

  vec_t vecs[15];

  initial begin
    //             v rs rt urs urt d  rw mr fl  stall a     b     cnt
    vecs[0]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 3'b000, 3'b000, 16'd0); // add r3,r1,r2
    vecs[1]  = mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 3'b001, 3'b000, 16'd0); // sub r5,r3,r4
    vecs[2]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 3'b000, 3'b000, 16'd0); // add r3,r1,r2
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 16'd0); // nop
    vecs[4]  = mk(1, 7, 3, 1, 1, 6, 1, 0, 0, 0, 3'b000, 3'b010, 16'd0); // or r6,r7,r3
    vecs[5]  = mk(1, 3, 3, 1, 1, 8, 1, 0, 0, 0, 3'b000, 3'b000, 16'd0); // and r8,r3,r3 (WB dep)
    vecs[6]  = mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 3'b000, 3'b000, 16'd0); // lw r2,0(r1)
    vecs[7]  = mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 1, 3'b000, 3'b000, 16'd1); // add r4,r2,r5 stall
    vecs[8]  = mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 0, 3'b010, 3'b000, 16'd1); // held add
    vecs[9]  = mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 3'b000, 3'b000, 16'd1); // addi r0,r1
    vecs[10] = mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 3'b000, 3'b000, 16'd1); // lw r0,0(r1)
    vecs[11] = mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 3'b000, 3'b000, 16'd1); // add r9,r0,r0
    vecs[12] = mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 3'b000, 3'b000, 16'd1); // lw r2,0(r1)
    vecs[13] = mk(1, 2, 5, 1, 1, 4, 1, 0, 1, 0, 3'b000, 3'b000, 16'd1); // add, flushed
    vecs[14] = mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 0, 3'b010, 3'b000, 16'd1); // add refetched

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 16'd0));
    i_reset = 1'b0;
    #3;
    chk("reset stall", {15'd0, o_stall}, 16'd0);
    chk("reset regA", {13'd0, o_corto_cir_regA}, 16'd0);
    chk("reset regB", {13'd0, o_corto_cir_regB}, 16'd0);
    chk("reset count", o_stall_count, 16'd0);
    @(negedge i_clk);
    i_reset = 1'b1;

    for (int i = 0; i < 15; i++)
      step(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back load-use, second hazard on the rt operand.
    step(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 3'b000, 3'b000, 16'd1), "b2b lw r2");
    step(mk(1, 2, 0, 1, 0, 3, 1, 1, 0, 1, 3'b000, 3'b000, 16'd2), "b2b lw r3 stall");
    step(mk(1, 2, 0, 1, 0, 3, 1, 1, 0, 0, 3'b010, 3'b000, 16'd2), "b2b lw r3 held");
    step(mk(1, 5, 3, 1, 1, 4, 1, 0, 0, 1, 3'b000, 3'b000, 16'd3), "b2b add stall");
    step(mk(1, 5, 3, 1, 1, 4, 1, 0, 0, 0, 3'b000, 3'b010, 16'd3), "b2b add held");

    // Reset asserted while in STALL.
    step(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 3'b000, 3'b000, 16'd3), "rst lw r2");
    step(mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 1, 3'b000, 3'b000, 16'd4), "rst add stall");
    @(negedge i_clk);
    #1 chk("in STALL no stall", {15'd0, o_stall}, 16'd0);
    i_reset = 1'b0;
    #1;
    chk("rst async stall", {15'd0, o_stall}, 16'd0);
    chk("rst async regA", {13'd0, o_corto_cir_regA}, 16'd0);
    chk("rst async regB", {13'd0, o_corto_cir_regB}, 16'd0);
    chk("rst async count", o_stall_count, 16'd0);
    i_reset = 1'b1;
    step(mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 0, 3'b000, 3'b000, 16'd0), "post rst add");
    step(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 3'b000, 3'b000, 16'd0), "post rst lw r2");
    @(negedge i_clk);
    drive(mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 0, 3'b000, 3'b000, 16'd0));
    #1 chk("post rst stall from RUN", {15'd0, o_stall}, 16'd1);
    i_reset = 1'b0;
    #1 chk("rst aborts stall", {15'd0, o_stall}, 16'd0);
    i_reset = 1'b1;

    // Saturation: preload the counter just below the limit.
    @(negedge i_clk);
    force dut.stall_count_q = 16'hFFFE;
    #1 release dut.stall_count_q;
    #1 chk("sat preload", o_stall_count, 16'hFFFE);
    step(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 3'b000, 3'b000, 16'hFFFE), "sat lw1");
    step(mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 1, 3'b000, 3'b000, 16'hFFFF), "sat stall1");
    step(mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 0, 3'b010, 3'b000, 16'hFFFF), "sat held1");
    step(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 3'b000, 3'b000, 16'hFFFF), "sat lw2");
    step(mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 1, 3'b000, 3'b000, 16'hFFFF), "sat stall2");
    step(mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 0, 3'b010, 3'b000, 16'hFFFF), "sat held2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
